// File: rtl/multi_dac_stream_packer.sv
// rtl/multi_dac_stream_packer.sv - packs DMA samples into DAC beats and releases them in lockstep
//
// Purpose:
//   Narrow samples from the DMA are packed SPB at a time into BW-bit beats.
//   Each complete beat goes to the next enabled channel FIFO in round-robin
//   order. While running, all enabled channels present and pop their FIFO
//   heads together, so every DAC output stays beat-aligned.
//
// Ports:
//   clk            rising-edge clock for all logic
//   rst            synchronous active-low reset
//   s_axis_tdata   input sample (SAMPLE_W bits)
//   s_axis_tvalid  input sample valid
//   s_axis_tready  input sample ready
//   ch_mask        channel enable, captured on flush
//   flush          clear FIFOs/packer/underflow and load ch_mask (IDLE only)
//   start          IDLE -> RUN
//   stop           RUN -> IDLE (wins over start)
//   m_axis_tdata   per-channel beats, channel c at [c*BW +: BW]
//   m_axis_tvalid  per-channel valid
//   m_axis_tready  per-channel ready
//   fifo_full      per-channel FIFO full
//   underflow      sticky per-channel underflow
//   busy           high while in RUN

module multi_dac_stream_packer #(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 16,
  parameter int SPB        = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SAMPLE_W-1:0]            s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [NUM_CH-1:0]              ch_mask,
  input  logic                           flush,
  input  logic                           start,
  input  logic                           stop,
  output logic [NUM_CH*SPB*SAMPLE_W-1:0] m_axis_tdata,
  output logic [NUM_CH-1:0]              m_axis_tvalid,
  input  logic [NUM_CH-1:0]              m_axis_tready,
  output logic [NUM_CH-1:0]              fifo_full,
  output logic [NUM_CH-1:0]              underflow,
  output logic                           busy
);

  localparam int BW = SPB * SAMPLE_W;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = (SPB > 1) ? $clog2(SPB) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [NUM_CH-1:0] mask_q;
  logic [CW-1:0]     ch_ptr;
  logic [CW-1:0]     ch_ptr_nx;
  logic [CW-1:0]     first_ptr;
  logic [PW-1:0]     pack_cnt;
  logic [BW-1:0]     lane_q;
  logic [BW-1:0]     wdata;

  logic [BW-1:0]     mem    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr [NUM_CH];
  logic [AW-1:0]     rd_ptr [NUM_CH];
  logic [AW:0]       cnt    [NUM_CH];

  logic [NUM_CH-1:0] not_empty;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] uf_set;

  logic run;
  logic do_flush;
  logic accept;
  logic last_lane;
  logic wr_beat;
  logic all_have;
  logic all_rdy;
  logic pop_all;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start && !stop) state_nx = ST_RUN;
      ST_RUN:  if (stop)           state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign run      = (state == ST_RUN);
  assign busy     = run;
  assign do_flush = flush && !run;

  // ---------------------------------------------------------------------
  // Channel pointer helpers
  // ---------------------------------------------------------------------
  // Lowest enabled channel of the incoming mask, used as the first target
  // after a flush.
  always_comb begin
    first_ptr = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (ch_mask[c]) first_ptr = CW'(c);
    end
  end

  // Next enabled channel above ch_ptr, wrapping. Scanning NUM_CH steps
  // ends back on ch_ptr itself, so a single enabled channel stays put.
  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    ch_ptr_nx = ch_ptr;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(ch_ptr) + k) % NUM_CH;
      if (!found && mask_q[idx]) begin
        ch_ptr_nx = CW'(idx);
        found     = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO status and lockstep release
  // ---------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      not_empty[c] = (cnt[c] != '0);
      fifo_full[c] = (cnt[c] == (AW + 1)'(FIFO_DEPTH));
    end
  end

  // Disabled channels count as satisfied so they never block the others.
  assign all_have = &(not_empty | ~mask_q);
  assign all_rdy  = &(m_axis_tready | ~mask_q);
  assign pop_all  = run && all_have && all_rdy && (mask_q != '0);
  assign pop      = pop_all ? mask_q : '0;
  assign uf_set   = (run && all_rdy) ? (mask_q & ~not_empty) : '0;

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask_q[c]) begin
        m_axis_tdata[c*BW +: BW] = mem[c][rd_ptr[c]];
        m_axis_tvalid[c]         = run && all_have;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Packer
  // ---------------------------------------------------------------------
  assign last_lane     = (pack_cnt == PW'(SPB - 1));
  assign s_axis_tready = (mask_q != '0) && !(last_lane && fifo_full[ch_ptr]);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign wr_beat       = accept && last_lane && !do_flush;

  // The last lane goes straight from the input into the FIFO word, so a
  // beat is written on the same edge its final sample is accepted.
  always_comb begin
    wdata = lane_q;
    wdata[(SPB-1)*SAMPLE_W +: SAMPLE_W] = s_axis_tdata;
  end

  always_comb begin
    wr_en = '0;
    if (wr_beat) wr_en[ch_ptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pack_cnt  <= '0;
      lane_q    <= '0;
      ch_ptr    <= '0;
      mask_q    <= '0;
      underflow <= '0;
    end else if (do_flush) begin
      pack_cnt  <= '0;
      ch_ptr    <= first_ptr;
      mask_q    <= ch_mask;
      underflow <= '0;
    end else begin
      underflow <= underflow | uf_set;
      if (accept) begin
        lane_q[pack_cnt*SAMPLE_W +: SAMPLE_W] <= s_axis_tdata;
        if (last_lane) begin
          pack_cnt <= '0;
          ch_ptr   <= ch_ptr_nx;
        end else begin
          pack_cnt <= pack_cnt + PW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel FIFOs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) mem[c][wr_ptr[c]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst || do_flush) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end else begin
        if (wr_en[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
        if (pop[c])   rd_ptr[c] <= rd_ptr[c] + AW'(1);
        case ({wr_en[c], pop[c]})
          2'b10:   cnt[c] <= cnt[c] + (AW + 1)'(1);
          2'b01:   cnt[c] <= cnt[c] - (AW + 1)'(1);
          default: cnt[c] <= cnt[c];
        endcase
      end
    end
  end

endmodule
